// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants and types for the instruction-fetch responder.
// Latency: none (declarations only).
// Backpressure: n/a.
package if_fetch_ctrl_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fetch_state_t;

  // Stall-request encoding toward the stall controller.
  localparam logic STOP         = 1'b1;
  localparam logic NO_STOP      = 1'b0;

  // Chip-enable encoding from the PC register.
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  // Instruction geometry: a 32-bit word fetched as four bytes.
  localparam int FETCH_INST_W = 32;
  localparam int FETCH_BYTES  = 4;
  localparam int BYTE_CNT_W   = 2;   // counts received bytes 0..3
  localparam int ISSUE_CNT_W  = 3;   // counts issued reads 0..4

endpackage

// File: rtl/if_byte_assembler.sv
// Collects four little-endian bytes into one instruction word.
// Latency: word_next is combinational; the stored word updates on the capture edge.
// Backpressure: none; the caller only asserts cap when a byte is on din.
//
// Ports: clk, rst (async active-low), clr (restart assembly), cap (capture din),
//        din (memory byte), last (this capture completes the word),
//        word_next (stored word with din inserted at the current byte slot).
module if_byte_assembler
  import if_fetch_ctrl_pkg::*;
#(
  parameter int INST_W = FETCH_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              cap,
  input  logic [7:0]        din,
  output logic              last,
  output logic [INST_W-1:0] word_next
);

  logic [BYTE_CNT_W-1:0] recv_cnt;
  logic [INST_W-1:0]     word_q;

  // The finished word is taken from word_next on the final capture, so the
  // caller never has to wait an extra cycle for the stored copy.
  always_comb begin
    word_next                   = word_q;
    word_next[8*recv_cnt +: 8]  = din;
  end

  assign last = cap && (recv_cnt == BYTE_CNT_W'(FETCH_BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      recv_cnt <= '0;
      word_q   <= '0;
    end else if (clr) begin
      recv_cnt <= '0;
      word_q   <= '0;
    end else if (cap) begin
      recv_cnt <= recv_cnt + BYTE_CNT_W'(1);
      word_q   <= word_next;
    end
  end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetches a 32-bit instruction at pc_i as four byte reads and holds the PC via stallreq_o.
// Latency: inst_valid_o six cycles after IDLE, plus one per busy issue cycle (one cycle on a buffer hit).
// Backpressure: mem_busy_i holds the issue counter; in-flight bytes are still captured.
//
// Ports: clk, rst (async active-low), pc_i, ce_i, flush_i, mem_busy_i, mem_din_i
//        -> mem_a_o, mem_rd_o, inst_o, inst_valid_o, stallreq_o.
// Build option: define IF_FETCH_BUF_EN for a one-entry last-fetch buffer.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int INST_W = FETCH_INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  input  logic              mem_busy_i,
  input  logic [7:0]        mem_din_i,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_rd_o,
  output logic [INST_W-1:0] inst_o,
  output logic              inst_valid_o,
  output logic              stallreq_o
);

  fetch_state_t            state_q, state_d;
  logic [ISSUE_CNT_W-1:0]  issue_q, issue_d;
  logic                    rd_pend_q;   // a read was issued last cycle; its byte is on mem_din_i now
  logic [INST_W-1:0]       inst_q;
  logic                    abort;
  logic                    asm_clr, asm_cap, asm_last;
  logic [INST_W-1:0]       asm_word;
  logic                    load_fetch, load_hit;
  logic                    buf_hit;
  logic [INST_W-1:0]       hit_data;
  logic [ADDR_W-1:0]       issue_addr;

  // Dropping chip-enable mid-fetch is treated exactly like a flush.
  assign abort      = flush_i || (ce_i == CHIP_DISABLE);
  assign issue_addr = pc_i[ADDR_W-1:0] + ADDR_W'(issue_q);

`ifdef IF_FETCH_BUF_EN
  logic              buf_valid;
  logic [31:0]       buf_tag;
  logic [INST_W-1:0] buf_data;

  // Flushes leave the buffer alone: its contents stay correct for its tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (load_fetch) begin
      buf_valid <= 1'b1;
      buf_tag   <= pc_i;
      buf_data  <= asm_word;
    end
  end

  assign buf_hit  = buf_valid && (buf_tag == pc_i);
  assign hit_data = buf_data;
`else
  logic unused_pc_hi;

  assign buf_hit      = 1'b0;
  assign hit_data     = '0;
  assign unused_pc_hi = ^pc_i[31:ADDR_W];
`endif

  if_byte_assembler #(
    .INST_W (INST_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .cap       (asm_cap),
    .din       (mem_din_i),
    .last      (asm_last),
    .word_next (asm_word)
  );

  always_comb begin
    state_d      = state_q;
    issue_d      = issue_q;
    mem_rd_o     = 1'b0;
    mem_a_o      = '0;
    asm_clr      = 1'b0;
    asm_cap      = 1'b0;
    load_fetch   = 1'b0;
    load_hit     = 1'b0;
    inst_valid_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!abort) begin
          asm_clr = 1'b1;
          issue_d = '0;
          if (buf_hit) begin
            state_d  = DONE;
            load_hit = 1'b1;
          end else begin
            state_d  = FETCH;
          end
        end
      end

      FETCH: begin
        // Abort wins over both issue and capture; the pending byte is dropped.
        if (abort) begin
          state_d = IDLE;
          issue_d = '0;
          asm_clr = 1'b1;
        end else begin
          if ((issue_q < ISSUE_CNT_W'(FETCH_BYTES)) && !mem_busy_i) begin
            mem_rd_o = 1'b1;
            mem_a_o  = issue_addr;
            issue_d  = issue_q + ISSUE_CNT_W'(1);
          end
          if (rd_pend_q) begin
            asm_cap = 1'b1;
            if (asm_last) begin
              state_d    = DONE;
              load_fetch = 1'b1;
            end
          end
        end
      end

      DONE: begin
        state_d      = IDLE;
        issue_d      = '0;
        asm_clr      = 1'b1;
        inst_valid_o = !abort;
      end

      default: begin
        state_d = IDLE;
        issue_d = '0;
        asm_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      issue_q   <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      issue_q   <= issue_d;
      rd_pend_q <= mem_rd_o;
    end
  end

  // inst_o only changes on entry to DONE, so it holds the last word otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_q <= '0;
    end else if (load_fetch) begin
      inst_q <= asm_word;
    end else if (load_hit) begin
      inst_q <= hit_data;
    end
  end

  assign inst_o = inst_q;

  // Gated by rst so the stall request drops immediately while reset is held.
  assign stallreq_o = (rst && (ce_i == CHIP_ENABLE) && (state_q != DONE) && !flush_i)
                      ? STOP : NO_STOP;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
module tb_if_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        flush_i;
  logic        mem_busy_i;
  logic [7:0]  mem_din_i;
  logic [16:0] mem_a_o;
  logic        mem_rd_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        stallreq_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:131071];

  typedef struct {
    logic        ce;
    logic        fl;
    logic        bz;
    logic [31:0] pc;
    logic        e_rd;
    logic [16:0] e_a;
    logic        e_vld;
    logic        e_stall;
    logic        chk_inst;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vq[$];

  if_fetch_ctrl #(
    .ADDR_W (17),
    .INST_W (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .ce_i         (ce_i),
    .flush_i      (flush_i),
    .mem_busy_i   (mem_busy_i),
    .mem_din_i    (mem_din_i),
    .mem_a_o      (mem_a_o),
    .mem_rd_o     (mem_rd_o),
    .inst_o       (inst_o),
    .inst_valid_o (inst_valid_o),
    .stallreq_o   (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-wide synchronous memory: data appears the cycle after its address.
  always @(posedge clk) begin
    if (mem_rd_o) mem_din_i <= mem[mem_a_o];
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic check_outs(input string nm, input logic e_rd, input logic [16:0] e_a,
                            input logic e_vld, input logic e_stall,
                            input logic chk_inst, input logic [31:0] e_inst);
    chk({nm, ".rd"},    32'(mem_rd_o),     32'(e_rd));
    chk({nm, ".a"},     32'(mem_a_o),      32'(e_a));
    chk({nm, ".vld"},   32'(inst_valid_o), 32'(e_vld));
    chk({nm, ".stall"}, 32'(stallreq_o),   32'(e_stall));
    if (chk_inst) chk({nm, ".inst"}, inst_o, e_inst);
  endtask

  // One cycle: inputs change just after the rising edge, outputs sampled on the falling edge.
  task automatic step(input logic ce, input logic fl, input logic bz, input logic [31:0] pc);
    @(posedge clk);
    #1;
    ce_i       = ce;
    flush_i    = fl;
    mem_busy_i = bz;
    pc_i       = pc;
    @(negedge clk);
  endtask

  task automatic add_vec(input logic ce, input logic fl, input logic bz, input logic [31:0] pc,
                         input logic rd, input logic [16:0] a, input logic v, input logic s,
                         input logic ci, input logic [31:0] inst);
    vq.push_back('{ce, fl, bz, pc, rd, a, v, s, ci, inst});
  endtask

  // Runs one fetch starting in IDLE; busy_cyc (if nonzero) raises mem_busy_i in that cycle.
  task automatic run_fetch(input string nm, input logic [31:0] pc, input int busy_cyc,
                           input logic [31:0] exp_inst, input bit hit);
    int          n;
    int          k;
    int          rd_cnt;
    logic        bz;
    logic        e_rd;
    logic [31:0] e_a;
    n      = hit ? 2 : ((busy_cyc != 0) ? 8 : 7);
    k      = 0;
    rd_cnt = 0;
    for (int c = 0; c < n; c++) begin
      bz = (busy_cyc != 0) && (c == busy_cyc);
      step(1'b1, 1'b0, bz, pc);
      e_rd = !hit && (c >= 1) && (k < 4) && !bz;
      e_a  = e_rd ? ((pc + 32'(k)) & 32'h0001_FFFF) : 32'h0;
      if (mem_rd_o) rd_cnt++;
      check_outs($sformatf("%s.c%0d", nm, c), e_rd, 17'(e_a), c == n - 1, c != n - 1,
                 c == n - 1, exp_inst);
      if (e_rd) k++;
    end
    if (hit) chk({nm, ".rdpulses"}, 32'(rd_cnt), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 131072; i++) mem[i] = 8'h00;
    mem[17'h00100] = 8'h13; mem[17'h00101] = 8'h05; mem[17'h00102] = 8'h10; mem[17'h00103] = 8'h00;
    mem[17'h00104] = 8'hb3; mem[17'h00105] = 8'h00; mem[17'h00106] = 8'h11; mem[17'h00107] = 8'h00;
    mem[17'h00200] = 8'h37; mem[17'h00201] = 8'h12; mem[17'h00202] = 8'h00; mem[17'h00203] = 8'h00;
    mem[17'h00300] = 8'h93; mem[17'h00301] = 8'h00; mem[17'h00302] = 8'h50; mem[17'h00303] = 8'h00;
    mem[17'h1FFFF] = 8'hAA; mem[17'h00000] = 8'hBB; mem[17'h00001] = 8'hCC; mem[17'h00002] = 8'hDD;

    // Basic fetch at 0x100.
    add_vec(1, 0, 0, 32'h100, 0, 17'h0,   0, 1, 1, 32'h0);
    add_vec(1, 0, 0, 32'h100, 1, 17'h100, 0, 1, 0, 32'h0);
    add_vec(1, 0, 0, 32'h100, 1, 17'h101, 0, 1, 0, 32'h0);
    add_vec(1, 0, 0, 32'h100, 1, 17'h102, 0, 1, 0, 32'h0);
    add_vec(1, 0, 0, 32'h100, 1, 17'h103, 0, 1, 0, 32'h0);
    add_vec(1, 0, 0, 32'h100, 0, 17'h0,   0, 1, 0, 32'h0);
    add_vec(1, 0, 0, 32'h100, 0, 17'h0,   1, 0, 1, 32'h00100513);
    // Idle for ten cycles; flush in IDLE is harmless; inst_o holds.
    for (int i = 0; i < 10; i++)
      add_vec(0, 1'(i % 3 == 1), 0, 32'h100 + 32'(4 * i), 0, 17'h0, 0, 0, 1, 32'h00100513);
    // Flush in cycle 3 of a fetch at 0x200, then refetch at 0x300.
    add_vec(1, 0, 0, 32'h200, 0, 17'h0,   0, 1, 1, 32'h00100513);
    add_vec(1, 0, 0, 32'h200, 1, 17'h200, 0, 1, 0, 32'h0);
    add_vec(1, 0, 0, 32'h200, 1, 17'h201, 0, 1, 0, 32'h0);
    add_vec(1, 1, 0, 32'h200, 0, 17'h0,   0, 0, 1, 32'h00100513);
    add_vec(1, 0, 0, 32'h300, 0, 17'h0,   0, 1, 1, 32'h00100513);
    add_vec(1, 0, 0, 32'h300, 1, 17'h300, 0, 1, 0, 32'h0);
    add_vec(1, 0, 0, 32'h300, 1, 17'h301, 0, 1, 0, 32'h0);
    add_vec(1, 0, 0, 32'h300, 1, 17'h302, 0, 1, 0, 32'h0);
    add_vec(1, 0, 0, 32'h300, 1, 17'h303, 0, 1, 0, 32'h0);
    add_vec(1, 0, 0, 32'h300, 0, 17'h0,   0, 1, 0, 32'h0);
    add_vec(1, 0, 0, 32'h300, 0, 17'h0,   1, 0, 1, 32'h00500093);
    add_vec(0, 0, 0, 32'h300, 0, 17'h0,   0, 0, 1, 32'h00500093);

    // Reset state, with ce_i high to confirm the stall request is gated.
    rst        = 1'b0;
    ce_i       = 1'b0;
    flush_i    = 1'b0;
    mem_busy_i = 1'b0;
    pc_i       = 32'h100;
    mem_din_i  = 8'h00;
    @(negedge clk);
    ce_i = 1'b1;
    #1;
    check_outs("reset", 0, 17'h0, 0, 0, 1, 32'h0);
    ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    foreach (vq[i]) begin
      step(vq[i].ce, vq[i].fl, vq[i].bz, vq[i].pc);
      check_outs($sformatf("vec%0d", i), vq[i].e_rd, vq[i].e_a, vq[i].e_vld, vq[i].e_stall,
                 vq[i].chk_inst, vq[i].e_inst);
    end

    // Repeated fetch of the same PC: buffer hit when the buffer is built in.
    run_fetch("rep1", 32'h100, 0, 32'h00100513, 0);
`ifdef IF_FETCH_BUF_EN
    run_fetch("rep2", 32'h100, 0, 32'h00100513, 1);
`else
    run_fetch("rep2", 32'h100, 0, 32'h00100513, 0);
`endif
    run_fetch("next", 32'h104, 0, 32'h001100b3, 0);

    // Reset asserted in cycle 4 of a fetch that wraps the address space.
    step(1, 0, 0, 32'h1FFFF);
    check_outs("mid.c0", 0, 17'h0,     0, 1, 0, 32'h0);
    step(1, 0, 0, 32'h1FFFF);
    check_outs("mid.c1", 1, 17'h1FFFF, 0, 1, 0, 32'h0);
    step(1, 0, 0, 32'h1FFFF);
    check_outs("mid.c2", 1, 17'h0,     0, 1, 0, 32'h0);
    step(1, 0, 0, 32'h1FFFF);
    check_outs("mid.c3", 1, 17'h1,     0, 1, 0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_outs("mid.rst", 0, 17'h0, 0, 0, 1, 32'h0);
    @(negedge clk);
    ce_i = 1'b0;
    rst  = 1'b1;

    // After reset: fetch 0x100 with the memory port busy in cycle 2.
    run_fetch("busy", 32'h100, 2, 32'h00100513, 0);
    // Address wrap modulo 2^17.
    run_fetch("wrap", 32'h1FFFF, 0, 32'hDDCCBBAA, 0);

    step(0, 0, 0, 32'h0);
    check_outs("end", 0, 17'h0, 0, 0, 1, 32'hDDCCBBAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
- Responder side of the PC/instruction-fetch interface. Takes the PC and chip-enable from the PC register, fetches a 32-bit instruction from byte-wide synchronous instruction memory with four sequential byte reads, and returns the assembled instruction.
- Raises a stall request until the instruction is ready, so the PC holds for the whole fetch.
- Sits between the PC register, the stall controller and the memory arbiter.

Parameters:
- ADDR_W, 17, memory address width; mem_a_o = lower ADDR_W bits of (pc_i + k).
- INST_W, 32, instruction width; fixed at 4 bytes.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- pc_i  in  32  current fetch address
- ce_i  in  1  chip enable from the PC register; 0 means idle, no fetch
- flush_i  in  1  abort the in-flight fetch (branch taken or pipeline flush)
- mem_busy_i  in  1  arbiter grants the memory port elsewhere this cycle
- mem_din_i  in  8  read data, valid the cycle after its address
- mem_a_o  out  ADDR_W  byte address to memory
- mem_rd_o  out  1  read strobe
- inst_o  out  32  assembled instruction
- inst_valid_o  out  1  inst_o valid for pc_i this cycle
- stallreq_o  out  1  stall request to the stall controller (PC-hold bit)

Behaviour:
- Reset (rst=0, any time, including mid-fetch):
  - State goes to IDLE; counters and buffer are cleared.
  - mem_a_o=0, mem_rd_o=0, inst_o=0, inst_valid_o=0.
  - stallreq_o=0.
- FSM states: IDLE, FETCH, DONE.
  - IDLE: if ce_i=1 and flush_i=0, go to FETCH with issue_cnt=0 and recv_cnt=0.
  - FETCH: while issue_cnt<4 and mem_busy_i=0, drive mem_a_o=pc_i+issue_cnt and mem_rd_o=1, then increment issue_cnt.
    - When mem_busy_i=1: mem_rd_o=0 and issue_cnt holds.
    - Any byte issued the previous cycle is still captured: byte recv_cnt lands in inst_o[8*recv_cnt+7 : 8*recv_cnt] (little-endian), then recv_cnt increments.
    - When the 4th byte is captured, go to DONE.
  - DONE: inst_valid_o=1 for exactly one cycle, then go to IDLE.
- stallreq_o = ce_i & ~(state==DONE) & ~flush_i. This is combinational, so the PC advances only at the end of the DONE cycle.
- Latency with no busy cycles:
  - IDLE at cycle 0.
  - Addresses in cycles 1–4.
  - Data in cycles 2–5.
  - DONE (inst_valid_o=1) in cycle 6.
  - Each cycle with mem_busy_i=1 during issue adds one cycle.
- inst_o holds its last value outside DONE. inst_valid_o=0 in every state except DONE.
- flush_i=1 in FETCH or DONE:
  - Next state is IDLE and counters clear.
  - Bytes still in flight are discarded; inst_valid_o is forced to 0 that cycle.
- flush_i in IDLE has no effect. flush_i has priority over busy and capture.
- ce_i=0: FSM stays in IDLE and issues no reads. A deassert mid-fetch aborts the fetch like flush_i.
- Address arithmetic wraps modulo 2^ADDR_W. pc_i is not checked for alignment.
- pc_i is guaranteed stable while stallreq_o=1, so no re-sampling is required.

Optional Feature:
- Macro: IF_FETCH_BUF_EN.
- Defined:
  - Adds a one-entry buffer: buf_valid, a 32-bit tag and the data of the last completed fetch, updated on entry to DONE.
  - In IDLE, if buf_valid=1 and tag==pc_i, go directly to DONE the next cycle with inst_o=buffer data and no memory reads (hit latency 1 cycle).
  - Reset clears buf_valid. A flush does not invalidate the buffer.
- Undefined: no buffer; every fetch takes the full memory sequence.

Decomposition:
- Shared defines file: the FSM state encodings, the Stop/NoStop and ChipEnable constants, and the INST_W and byte-count constants.
- A sub-module is natural: if_byte_assembler, holding recv_cnt and the 4-byte shift/insert register with a clear input.

Test Plan:
1. Basic fetch: ce_i=1, pc_i=0x100; memory at 0x100..0x103 = 13 05 10 00 → reads 0x100..0x103 in cycles 1–4, inst_o=0x00100513 and inst_valid_o=1 in cycle 6, stallreq_o=1 in cycles 0–5 and 0 in cycle 6.
2. Arbitration: same as test 1 with mem_busy_i=1 in cycle 2 → mem_rd_o=0 in cycle 2, address 0x101 reissued in cycle 3, valid in cycle 7 with the same data.
3. Flush: flush_i=1 in cycle 3 of a fetch at 0x200, then pc_i=0x300 → no valid for 0x200; the next reads start at 0x300 and return the correct instruction 6 cycles after IDLE.
4. Reset: rst=0 in cycle 4 → all outputs are 0 immediately (asynchronously); after release, fetch restarts from the IDLE timeline.
5. Idle: ce_i=0 for 10 cycles → mem_rd_o=0, stallreq_o=0, inst_valid_o=0 throughout.
6. IF_FETCH_BUF_EN: fetch 0x100, then fetch 0x100 again → second fetch has valid in cycle 1, zero mem_rd_o pulses, inst_o=0x00100513; then fetch 0x104 → full 6-cycle sequence.
